// File: rtl/alu_issue_pkg.sv
// Shared encodings, register addresses and decode helpers for the ALU issue stage.
package alu_issue_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic REG_A = 1'b0;
  localparam logic REG_B = 1'b1;

  // add $0,$0,$0: harmless encoding the ALU sees whenever nothing is issued
  localparam logic [31:0] NOP_WORD = 32'h0000_0020;

  typedef enum logic [1:0] {IDLE, EXEC, RETIRE} state_t;

  function automatic logic is_legal(input logic [31:0] instr);
    logic w_ops_ok;
    logic w_enc_ok;
    w_ops_ok = (instr[25:21] <= 5'd1) && (instr[20:16] <= 5'd1);
    w_enc_ok = 1'b0;
    if (instr[31:26] == OP_RTYPE) begin
      case (instr[5:0])
        FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_NOR, FN_OR, FN_XOR,
        FN_SLT, FN_SLTU, FN_SLL, FN_SLLV, FN_SRL, FN_SRLV, FN_SRA, FN_SRAV:
          w_enc_ok = 1'b1;
        default: w_enc_ok = 1'b0;
      endcase
    end else begin
      case (instr[31:26])
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_BEQ, OP_BNE,
        OP_SLTI, OP_SLTIU, OP_LW, OP_SW:
          w_enc_ok = 1'b1;
        default: w_enc_ok = 1'b0;
      endcase
    end
    return w_ops_ok && w_enc_ok;
  endfunction

  // Returns {valid, addr}; rd beyond the two-entry array yields no write.
  function automatic logic [1:0] wb_dest(input logic [31:0] instr);
    logic [1:0] w_dest;
    w_dest = 2'b00;
    case (instr[31:26])
      OP_RTYPE: w_dest = {(instr[15:11] <= 5'd1), instr[11]};
      OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU:
        w_dest = {1'b1, instr[16]};
      default: w_dest = 2'b00;
    endcase
    return w_dest;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Instruction FIFO: circular storage, wrap-around pointers, occupancy and registered in_ready.
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     in_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;
  logic          r_in_ready;
  logic          w_push;
  logic          w_pop;

  assign w_push = push && r_in_ready;
  assign w_pop  = pop && (r_count != '0);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNT_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_in_ready <= 1'b1;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < FULL_COUNT);
    end
  end

  assign head     = r_mem[r_rd_ptr];
  assign count    = r_count;
  assign in_ready = r_in_ready;

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage feeding a combinational ALU: FIFO, two-entry register array, retire handshake.
// Optional sticky overflow flag is built only with ALU_ISSUE_STICKY_OVF_EN defined.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] REGA_INIT = 32'h0,
  parameter logic [31:0] REGB_INIT = 32'h0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     load_valid,
  input  logic                     load_addr,
  input  logic [31:0]              load_data,
  output logic [31:0]              alu_instr,
  output logic [31:0]              alu_rega,
  output logic [31:0]              alu_regb,
  input  logic [31:0]              alu_result,
  input  logic [2:0]               alu_flags,
  output logic                     ret_valid,
  input  logic                     ret_ready,
  output logic [31:0]              ret_instr,
  output logic [31:0]              ret_result,
  output logic [2:0]               ret_flags,
  output logic                     err_drop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     sticky_ovf
);

  state_t                    r_state;
  state_t                    w_state_next;
  logic [31:0]               w_head;
  logic [$clog2(DEPTH):0]    w_count;
  logic                      w_pop;
  logic                      w_drop;
  logic                      w_capture;
  logic                      w_retire;
  logic [1:0]                w_wb;
  logic [31:0]               r_regs [2];
  logic [31:0]               r_ret_instr;
  logic [31:0]               r_ret_result;
  logic [2:0]                r_ret_flags;

  alu_issue_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid),
    .pop      (w_pop),
    .din      (in_instr),
    .head     (w_head),
    .count    (w_count),
    .in_ready (in_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_drop       = 1'b0;
    w_capture    = 1'b0;
    w_retire     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_count != '0) begin
          if (!is_legal(w_head)) begin
            w_pop  = 1'b1;
            w_drop = 1'b1;
          end else begin
            w_state_next = EXEC;
          end
        end
      end
      EXEC: begin
        w_capture    = 1'b1;
        w_state_next = RETIRE;
      end
      RETIRE: begin
        if (ret_ready) begin
          w_retire     = 1'b1;
          w_pop        = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ret_instr  <= '0;
      r_ret_result <= '0;
      r_ret_flags  <= '0;
    end else if (w_capture) begin
      r_ret_instr  <= w_head;
      r_ret_result <= alu_result;
      r_ret_flags  <= alu_flags;
    end
  end

  assign w_wb = wb_dest(r_ret_instr);

  // Writeback is applied after the load so it wins a same-register collision.
  for (genvar gi = 0; gi < 2; gi++) begin : g_reg
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_regs[gi] <= (gi == 0) ? REGA_INIT : REGB_INIT;
      end else begin
        if (load_valid && (load_addr == gi[0])) r_regs[gi] <= load_data;
        if (w_retire && w_wb[1] && (w_wb[0] == gi[0])) r_regs[gi] <= r_ret_result;
      end
    end
  end

`ifdef ALU_ISSUE_STICKY_OVF_EN
  logic r_sticky_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            r_sticky_ovf <= 1'b0;
    else if (w_retire && r_ret_flags[0]) r_sticky_ovf <= 1'b1;
  end
  assign sticky_ovf = r_sticky_ovf;
`else
  assign sticky_ovf = 1'b0;
`endif

  assign alu_instr  = ((r_state == EXEC) || (r_state == RETIRE)) ? w_head : NOP_WORD;
  assign alu_rega   = r_regs[REG_A];
  assign alu_regb   = r_regs[REG_B];
  assign ret_valid  = (r_state == RETIRE);
  assign ret_instr  = r_ret_instr;
  assign ret_result = r_ret_result;
  assign ret_flags  = r_ret_flags;
  assign err_drop   = w_drop;
  assign count      = w_count;

endmodule
